rr_crossbar: RTL and testbench
==============================

RR_CROSSBAR -- requirements
Module: rr_crossbar

Interface
REQ-001 Parameter N_MASTER, default 2, number of master ports; SHALL be 2..8.
REQ-002 Parameter N_SLAVE, default 2, number of slave ports; SHALL be a power of two, 2..8.
REQ-003 Parameter ADDR_W, default 32, address width.
REQ-004 Parameter DATA_W, default 32, data width.
REQ-005 clk  input  1  single clock; every register SHALL update on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 m_req  input  N_MASTER  per-master request; held until m_ack.
REQ-008 m_cmd  input  N_MASTER  per-master command: 0 = read, 1 = write.
REQ-009 m_addr  input  N_MASTER*ADDR_W  flattened addresses; master i at bits [i*ADDR_W +: ADDR_W].
REQ-010 m_wdata  input  N_MASTER*DATA_W  flattened write data.
REQ-011 m_ack  output  N_MASTER  per-master acknowledge.
REQ-012 m_rdata  output  N_MASTER*DATA_W  flattened read data.
REQ-013 s_req, s_cmd  output  N_SLAVE each  per-slave request and command.
REQ-014 s_addr, s_wdata  output  N_SLAVE*ADDR_W, N_SLAVE*DATA_W  flattened slave address and write data.
REQ-015 s_ack  input  N_SLAVE  per-slave acknowledge.
REQ-016 s_rdata  input  N_SLAVE*DATA_W  per-slave read data, valid the cycle after the s_ack of a read.

Function
REQ-017 Target slave of master i SHALL be m_addr[i][ADDR_W-1 -: log2(N_SLAVE)]; the full address SHALL be forwarded unmodified.
REQ-018 Each slave SHALL have an independent FSM with states IDLE and LOCKED and an owner register.
REQ-019 IDLE: if any master targets the slave with m_req=1, the arbiter SHALL select one in the same cycle and drive s_req=1 with that master's cmd/addr/wdata.
REQ-020 IDLE and selected with s_ack=0: SHALL go to LOCKED with owner=selected master; with s_ack=1: SHALL stay IDLE.
REQ-021 LOCKED: SHALL drive the owner's signals regardless of other requests; on s_ack=1 SHALL return to IDLE.
REQ-022 m_ack[i] SHALL equal s_ack[j] when slave j is currently granted to master i, else 0; it is combinational, with zero added latency.
REQ-023 No s_req SHALL be asserted while the selected or owning master has m_req=0; with no requesters, s_req=0 and s_cmd/s_addr/s_wdata=0.
REQ-024 On an acked read (s_ack[j]=1, granted master i, cmd=0), rd_pend[i] SHALL be set for one cycle with rd_src[i]=j; in that cycle m_rdata[i]=s_rdata[j].
REQ-025 When rd_pend[i]=0, m_rdata[i] SHALL be 0.
REQ-026 Different slaves SHALL serve different masters concurrently; a master targets at most one slave at a time.
REQ-027 A master that drops m_req while LOCKED is a protocol violation; behaviour is undefined, and the FSM SHALL remain LOCKED until s_ack.
REQ-028 Back-to-back: a master with m_req held after its ack SHALL be eligible for re-arbitration in the next cycle.

Reset
REQ-029 When reset=1 at a clock edge, all FSMs SHALL enter IDLE, owners and rr_ptr SHALL be 0, and rd_pend SHALL be all 0.
REQ-030 During and after reset, m_ack=0 and m_rdata=0 SHALL hold until a new grant; s_req is gated as in REQ-023.
REQ-031 A reset asserted mid-transaction SHALL abort it: no m_ack and no read data SHALL be delivered for it.

Configuration
REQ-032 Macro RR_CROSSBAR_RR_EN defined: each slave SHALL keep an rr_ptr; selection SHALL be the first requester at or after rr_ptr (cyclic), and on s_ack rr_ptr SHALL become winner+1 mod N_MASTER.
REQ-033 RR_CROSSBAR_RR_EN undefined: selection SHALL be fixed priority, lowest index wins, and no rr_ptr register SHALL exist.

Verification
REQ-034 All scenarios SHALL use N_MASTER=2, N_SLAVE=2, ADDR_W=32, DATA_W=32.
REQ-035 Write: M0 writes addr 0x0000_0010, wdata 0xDEAD_BEEF; S0 acks in the 3rd cycle -> S0 sees the stable addr/data for 3 cycles, and m_ack[0] pulses once.
REQ-036 Read: M1 reads 0x8000_0004; S1 acks, then returns 0x1234_5678 the next cycle -> m_rdata[1]=0x1234_5678 for exactly that cycle, and 0 otherwise.
REQ-037 Contention (RR_CROSSBAR_RR_EN defined): both masters request S0 continuously with 1-cycle acks -> grants alternate M0, M1, M0, M1.
REQ-038 Contention (RR_CROSSBAR_RR_EN undefined): same stimulus as REQ-037 -> M0 is granted every cycle.
REQ-039 Lock plus parallel traffic: M0 locked on S0 (ack delayed 4 cycles) while M1 targets S0 -> M1 is not granted until the cycle after M0's ack; meanwhile M1 traffic to S1 proceeds in parallel.
REQ-040 Reset mid-transaction: reset at cycle 2 of a LOCKED read -> FSM is IDLE, rd_pend=0, and no m_ack or m_rdata is observed for that read.

Source files
------------

// File: rtl/rr_crossbar.sv
// rr_crossbar: N_MASTER x N_SLAVE request/ack crossbar with one arbiter FSM per slave.
//
// Build option: define RR_CROSSBAR_RR_EN for per-slave round-robin arbitration;
// left undefined, each slave uses fixed priority (lowest master index wins).
//
// Ports
//   clk, reset        single clock, synchronous active-high reset
//   m_req/m_cmd       per-master request (held until m_ack) and command (0 rd, 1 wr)
//   m_addr/m_wdata    flattened master address / write data, master i at [i*W +: W]
//   m_ack/m_rdata     per-master combinational ack, registered-select read data
//   s_req/s_cmd       per-slave request and command
//   s_addr/s_wdata    flattened slave address / write data (address forwarded unmodified)
//   s_ack/s_rdata     per-slave ack; read data valid the cycle after a read ack
module rr_crossbar #(
  parameter int N_MASTER = 2,
  parameter int N_SLAVE  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_MASTER-1:0]          m_req,
  input  logic [N_MASTER-1:0]          m_cmd,
  input  logic [N_MASTER*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTER*DATA_W-1:0]   m_wdata,
  output logic [N_MASTER-1:0]          m_ack,
  output logic [N_MASTER*DATA_W-1:0]   m_rdata,
  output logic [N_SLAVE-1:0]           s_req,
  output logic [N_SLAVE-1:0]           s_cmd,
  output logic [N_SLAVE*ADDR_W-1:0]    s_addr,
  output logic [N_SLAVE*DATA_W-1:0]    s_wdata,
  input  logic [N_SLAVE-1:0]           s_ack,
  input  logic [N_SLAVE*DATA_W-1:0]    s_rdata
);

  localparam int MW = $clog2(N_MASTER);
  localparam int SW = $clog2(N_SLAVE);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e              state_q [N_SLAVE];
  state_e              state_d [N_SLAVE];
  logic [MW-1:0]       owner_q [N_SLAVE];
  logic [MW-1:0]       owner_d [N_SLAVE];
`ifdef RR_CROSSBAR_RR_EN
  logic [MW-1:0]       rr_ptr_q [N_SLAVE];
  logic [MW-1:0]       rr_ptr_d [N_SLAVE];
`endif
  logic [N_MASTER-1:0] rd_pend_q, rd_pend_d;
  logic [SW-1:0]       rd_src_q [N_MASTER];
  logic [SW-1:0]       rd_src_d [N_MASTER];

  logic [SW-1:0]       tgt     [N_MASTER];
  logic [N_MASTER-1:0] cand    [N_SLAVE];
  logic [N_SLAVE-1:0]  sel_vld;
  logic [MW-1:0]       sel_idx [N_SLAVE];
  logic [N_SLAVE-1:0]  gnt_vld;
  logic [MW-1:0]       gnt_idx [N_SLAVE];

  // Target slave is the top SW address bits.
  always_comb begin
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      tgt[i] = m_addr[i*ADDR_W + ADDR_W - SW +: SW];
    end
  end

  // Arbitration among requesters of each slave (used only while IDLE).
  always_comb begin
`ifdef RR_CROSSBAR_RR_EN
    int unsigned idx;
    idx = 0;
`endif
    for (int unsigned j = 0; j < N_SLAVE; j++) begin
      sel_vld[j] = 1'b0;
      sel_idx[j] = '0;
      for (int unsigned i = 0; i < N_MASTER; i++) begin
        cand[j][i] = m_req[i] && (tgt[i] == SW'(j));
      end
      for (int unsigned k = 0; k < N_MASTER; k++) begin
`ifdef RR_CROSSBAR_RR_EN
        idx = (32'(rr_ptr_q[j]) + k) % N_MASTER;
        if (!sel_vld[j] && cand[j][idx]) begin
          sel_vld[j] = 1'b1;
          sel_idx[j] = MW'(idx);
        end
`else
        if (!sel_vld[j] && cand[j][k]) begin
          sel_vld[j] = 1'b1;
          sel_idx[j] = MW'(k);
        end
`endif
      end
    end
  end

  // Grant and slave-side muxing; a locked owner that drops m_req yields s_req=0.
  always_comb begin
    for (int unsigned j = 0; j < N_SLAVE; j++) begin
      if (state_q[j] == LOCKED) begin
        gnt_idx[j] = owner_q[j];
        gnt_vld[j] = m_req[owner_q[j]];
      end else begin
        gnt_idx[j] = sel_idx[j];
        gnt_vld[j] = sel_vld[j];
      end
      s_req[j] = gnt_vld[j];
      s_cmd[j] = gnt_vld[j] & m_cmd[gnt_idx[j]];
      s_addr[j*ADDR_W +: ADDR_W]  = gnt_vld[j] ? m_addr[32'(gnt_idx[j])*ADDR_W +: ADDR_W]  : '0;
      s_wdata[j*DATA_W +: DATA_W] = gnt_vld[j] ? m_wdata[32'(gnt_idx[j])*DATA_W +: DATA_W] : '0;
    end
  end

  // Master-side ack and read-pending capture; reset suppresses delivery.
  always_comb begin
    m_ack     = '0;
    rd_pend_d = '0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      rd_src_d[i] = rd_src_q[i];
    end
    for (int unsigned j = 0; j < N_SLAVE; j++) begin
      if (gnt_vld[j] && s_ack[j] && !reset) begin
        m_ack[gnt_idx[j]] = 1'b1;
        if (!s_cmd[j]) begin
          rd_pend_d[gnt_idx[j]] = 1'b1;
          rd_src_d[gnt_idx[j]]  = SW'(j);
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      m_rdata[i*DATA_W +: DATA_W] = rd_pend_q[i] ? s_rdata[32'(rd_src_q[i])*DATA_W +: DATA_W] : '0;
    end
  end

  // Per-slave next state.
  always_comb begin
    for (int unsigned j = 0; j < N_SLAVE; j++) begin
      state_d[j] = state_q[j];
      owner_d[j] = owner_q[j];
`ifdef RR_CROSSBAR_RR_EN
      rr_ptr_d[j] = rr_ptr_q[j];
`endif
      case (state_q[j])
        IDLE: begin
          if (sel_vld[j]) begin
            if (s_ack[j]) begin
`ifdef RR_CROSSBAR_RR_EN
              rr_ptr_d[j] = (sel_idx[j] == MW'(N_MASTER-1)) ? '0 : sel_idx[j] + 1'b1;
`endif
            end else begin
              state_d[j] = LOCKED;
              owner_d[j] = sel_idx[j];
            end
          end
        end
        LOCKED: begin
          if (s_ack[j]) begin
            state_d[j] = IDLE;
`ifdef RR_CROSSBAR_RR_EN
            rr_ptr_d[j] = (owner_q[j] == MW'(N_MASTER-1)) ? '0 : owner_q[j] + 1'b1;
`endif
          end
        end
        default: state_d[j] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned j = 0; j < N_SLAVE; j++) begin
        state_q[j] <= IDLE;
        owner_q[j] <= '0;
`ifdef RR_CROSSBAR_RR_EN
        rr_ptr_q[j] <= '0;
`endif
      end
      rd_pend_q <= '0;
      for (int unsigned i = 0; i < N_MASTER; i++) begin
        rd_src_q[i] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < N_SLAVE; j++) begin
        state_q[j] <= state_d[j];
        owner_q[j] <= owner_d[j];
`ifdef RR_CROSSBAR_RR_EN
        rr_ptr_q[j] <= rr_ptr_d[j];
`endif
      end
      rd_pend_q <= rd_pend_d;
      for (int unsigned i = 0; i < N_MASTER; i++) begin
        rd_src_q[i] <= rd_src_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rr_crossbar.sv
module tb_rr_crossbar;

  localparam int NM = 2;
  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk;
  logic              reset;
  logic [NM-1:0]     m_req, m_cmd, m_ack;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata, m_rdata;
  logic [NS-1:0]     s_req, s_cmd, s_ack;
  logic [NS*AW-1:0]  s_addr;
  logic [NS*DW-1:0]  s_wdata, s_rdata;

  rr_crossbar #(.N_MASTER(NM), .N_SLAVE(NS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: per slave a lock flag, owner and rotation pointer;
  // per master a pending-read flag and source slave.
  int lk [NS], own [NS], ptr [NS];
  int pend [NM], src [NM];
  int g [NS];
  logic [NM-1:0] e_ack;
  int npend [NM], nsrc [NM];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int tgt_of(input int m);
    return int'(m_addr[m*AW + AW - 1]);
  endfunction

  task automatic model_eval();
    for (int j = 0; j < NS; j++) begin
      g[j] = -1;
      if (lk[j] != 0) begin
        if (m_req[own[j]]) g[j] = own[j];
      end else begin
        for (int k = 0; k < NM; k++) begin
          int m;
`ifdef RR_CROSSBAR_RR_EN
          m = (ptr[j] + k) % NM;
`else
          m = k;
`endif
          if (g[j] < 0 && m_req[m] && tgt_of(m) == j) g[j] = m;
        end
      end
    end
    e_ack = '0;
    for (int i = 0; i < NM; i++) begin
      npend[i] = 0;
      nsrc[i]  = src[i];
    end
    for (int j = 0; j < NS; j++) begin
      if (g[j] >= 0 && s_ack[j] && !reset) begin
        e_ack[g[j]] = 1'b1;
        if (!m_cmd[g[j]]) begin
          npend[g[j]] = 1;
          nsrc[g[j]]  = j;
        end
      end
    end
  endtask

  task automatic model_update();
    if (reset) begin
      for (int j = 0; j < NS; j++) begin lk[j] = 0; own[j] = 0; ptr[j] = 0; end
      for (int i = 0; i < NM; i++) begin pend[i] = 0; src[i] = 0; end
    end else begin
      for (int i = 0; i < NM; i++) begin pend[i] = npend[i]; src[i] = nsrc[i]; end
      for (int j = 0; j < NS; j++) begin
        if (lk[j] != 0) begin
          if (s_ack[j]) begin lk[j] = 0; ptr[j] = (own[j] + 1) % NM; end
        end else if (g[j] >= 0) begin
          if (s_ack[j]) ptr[j] = (g[j] + 1) % NM;
          else begin lk[j] = 1; own[j] = g[j]; end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NM; i++) begin
      chk($sformatf("m_ack[%0d]", i), 64'(m_ack[i]), 64'(e_ack[i]));
      chk($sformatf("m_rdata[%0d]", i), 64'(m_rdata[i*DW +: DW]),
          (pend[i] != 0) ? 64'(s_rdata[src[i]*DW +: DW]) : 64'h0);
    end
    for (int j = 0; j < NS; j++) begin
      int gs;
      gs = (g[j] < 0) ? 0 : g[j];
      chk($sformatf("s_req[%0d]", j), 64'(s_req[j]), 64'(g[j] >= 0));
      chk($sformatf("s_cmd[%0d]", j), 64'(s_cmd[j]), (g[j] >= 0) ? 64'(m_cmd[gs]) : 64'h0);
      chk($sformatf("s_addr[%0d]", j), 64'(s_addr[j*AW +: AW]),
          (g[j] >= 0) ? 64'(m_addr[gs*AW +: AW]) : 64'h0);
      chk($sformatf("s_wdata[%0d]", j), 64'(s_wdata[j*DW +: DW]),
          (g[j] >= 0) ? 64'(m_wdata[gs*DW +: DW]) : 64'h0);
    end
  endtask

  task automatic settle();
    #4;
    model_eval();
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic idle_inputs();
    m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack = '0; s_rdata = {32'hAAAA5555, 32'h5A5A5A5A};
  endtask

  initial begin
    int acks, held;
    logic [NM-1:0] exp_seq;

    idle_inputs();
    reset = 1'b1;
    tick();
    // Reset state under reset, then idle after release.
    cyc();
    reset = 1'b0;
    cyc();

    // Write on S0 with ack in the third cycle.
    m_req = 2'b01; m_cmd = 2'b01;
    m_addr[31:0] = 32'h0000_0010; m_wdata[31:0] = 32'hDEAD_BEEF;
    acks = 0; held = 0;
    for (int c = 0; c < 5; c++) begin
      s_ack[0] = (c == 2);
      if (c == 3) m_req[0] = 1'b0;
      settle();
      if (m_ack[0]) acks++;
      if (s_req[0] && s_cmd[0] && s_addr[31:0] == 32'h10 && s_wdata[31:0] == 32'hDEAD_BEEF) held++;
      tick();
    end
    chk("wr_ack_pulses", 64'(acks), 64'd1);
    chk("wr_stable_cycles", 64'(held), 64'd3);

    // Read on S1, data returned the cycle after the ack.
    idle_inputs();
    m_req = 2'b10; m_addr[63:32] = 32'h8000_0004; s_ack = 2'b10;
    settle();
    chk("rd_ack", 64'(m_ack), 64'b10);
    tick();
    m_req = '0; s_ack = '0; s_rdata[63:32] = 32'h1234_5678;
    settle();
    chk("rd_data", 64'(m_rdata[63:32]), 64'h1234_5678);
    tick();
    settle();
    chk("rd_data_gone", 64'(m_rdata[63:32]), 64'h0);
    tick();

    // Contention on S0 with single-cycle acks.
    idle_inputs();
    reset = 1'b1; cyc(); reset = 1'b0;
    m_req = 2'b11; m_cmd = 2'b11;
    m_addr = {32'h0000_0200, 32'h0000_0100}; m_wdata = {32'h2222_2222, 32'h1111_1111};
    s_ack = 2'b01;
    for (int c = 0; c < 4; c++) begin
      settle();
`ifdef RR_CROSSBAR_RR_EN
      exp_seq = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_seq = 2'b01;
`endif
      chk($sformatf("contend_grant%0d", c), 64'(m_ack), 64'(exp_seq));
      tick();
    end

    // M0 locked on S0 while M1 works S1, then M1 waits for S0.
    idle_inputs();
    reset = 1'b1; cyc(); reset = 1'b0;
    m_req = 2'b11; m_cmd = 2'b01;
    m_addr = {32'h8000_0008, 32'h0000_0020}; m_wdata[31:0] = 32'hCAFE_0000;
    s_ack = 2'b10;
    settle(); chk("par_c0_ack", 64'(m_ack), 64'b10); tick();
    m_addr[63:32] = 32'h8000_000C;
    settle(); chk("par_c1_ack", 64'(m_ack), 64'b10);
    chk("par_c1_s0addr", 64'(s_addr[31:0]), 64'h20); tick();
    m_addr[63:32] = 32'h0000_0040; m_cmd[1] = 1'b1; m_wdata[63:32] = 32'hBEEF_0001; s_ack = 2'b00;
    settle(); chk("par_c2_ack", 64'(m_ack), 64'b00);
    chk("par_c2_s0addr", 64'(s_addr[31:0]), 64'h20); tick();
    s_ack = 2'b01;
    settle(); chk("par_c3_ack", 64'(m_ack), 64'b01);
    chk("par_c3_s0addr", 64'(s_addr[31:0]), 64'h20); tick();
    m_req[0] = 1'b0;
    settle(); chk("par_c4_ack", 64'(m_ack), 64'b10);
    chk("par_c4_s0addr", 64'(s_addr[31:0]), 64'h40); tick();
    idle_inputs();
    cyc();

    // Reset during a locked read aborts it.
    m_req = 2'b01; m_cmd = 2'b00; m_addr[31:0] = 32'h0000_0030;
    cyc(); cyc();
    reset = 1'b1; s_ack = 2'b01;
    settle(); chk("rst_mid_ack", 64'(m_ack), 64'h0); tick();
    reset = 1'b0; m_req = '0; s_ack = '0; s_rdata = {32'h7777_7777, 32'h9999_9999};
    settle();
    chk("rst_mid_rdata", 64'(m_rdata), 64'h0);
    chk("rst_mid_sreq", 64'(s_req), 64'h0);
    tick();
    cyc();

    // Randomized traffic, masters holding requests until acked.
    idle_inputs();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NM; i++) begin
        if (!m_req[i] && $urandom_range(0, 2) == 0) begin
          m_req[i] = 1'b1;
          m_cmd[i] = 1'($urandom_range(0, 1));
          m_addr[i*AW +: AW]  = $urandom;
          m_wdata[i*DW +: DW] = $urandom;
        end
      end
      for (int j = 0; j < NS; j++) s_ack[j] = 1'($urandom_range(0, 1));
      s_rdata = {$urandom, $urandom};
      reset = ($urandom_range(0, 59) == 0);
      settle();
      tick();
      for (int i = 0; i < NM; i++) begin
        if (e_ack[i]) begin
          if ($urandom_range(0, 1) == 0) begin
            m_req[i] = 1'b0;
          end else begin
            m_cmd[i] = 1'($urandom_range(0, 1));
            m_addr[i*AW +: AW]  = $urandom;
            m_wdata[i*DW +: DW] = $urandom;
          end
        end
      end
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
